mem_access_ctrl: RTL and testbench

Bus master sitting between the CPU core's load/store/fetch logic and the test memory model. It accepts one access request at a time from the core over a valid/ready handshake, drives the memory's req_rdwr/addr/data/size/we interface, and holds it stable until the memory's registered data_ready is seen. It returns read data or a write acknowledge to the core with a one-cycle response pulse. An optional timeout aborts hung accesses.

---
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding bus master between the core's
// load/store/fetch logic and the test memory model.
//
// A request accepted over the core valid/ready handshake is latched,
// presented to memory (ISSUE), held stable until the memory's registered
// data_ready (WAIT), and completed with a one-cycle response pulse (RESP).
// A 16-bit access at the top address is rejected without touching memory,
// because its second byte would wrap to address 0.
//
// Optional build macro MEM_ACCESS_CTRL_TIMEOUT_EN: adds an 8-bit WAIT
// counter that aborts the access with an error after TIMEOUT_CYCLES WAIT
// cycles without data_ready. When the macro is undefined WAIT waits forever.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W         = 16,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd32
) (
   input  logic              clk,
   input  logic              reset,
   // core side
   input  logic              core_req_valid,
   output logic              core_req_ready,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_we,
   input  logic              core_sz,
   input  logic [15:0]       core_wdata,
   output logic              core_resp_valid,
   output logic              core_resp_err,
   output logic [15:0]       core_rdata,
   // memory side
   output logic              mem_req_rdwr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_write_data_8,
   output logic [15:0]       mem_write_data_16,
   output logic              mem_data_acc_sz,
   output logic              mem_write_we,
   input  logic [7:0]        mem_read_data_8,
   input  logic [15:0]       mem_read_data_16,
   input  logic              mem_data_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              sz_q, sz_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [15:0]       rdata_q, rdata_d;
   // High only during the first WAIT cycle, where a lingering data_ready
   // from the previous access must not be taken as completion.
   logic              first_q, first_d;
   logic              mem_done;
   logic              active;
   logic              wraps;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = TIMEOUT_CYCLES - 8'd1;
   logic [7:0]        tmo_q, tmo_d;
`else
   logic              unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   assign mem_done = mem_data_ready && !first_q;
   assign active   = (state_q == ISSUE) || (state_q == WAIT);
   assign wraps    = core_sz && (core_addr == {ADDR_W{1'b1}});

   // Next-state, request latching and read-data capture.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      sz_d    = sz_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      first_d = 1'b0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (core_req_valid) begin
               addr_d  = core_addr;
               we_d    = core_we;
               sz_d    = core_sz;
               wdata_d = core_wdata;
               if (wraps) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            first_d = 1'b1;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            tmo_d   = 8'd0;
`endif
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_done) begin
               if (!we_q) begin
                  rdata_d = sz_q ? mem_read_data_16 : {8'h00, mem_read_data_8};
               end
               state_d = RESP;
            end
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset returns to an idle, empty controller.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         sz_q    <= 1'b0;
         wdata_q <= 16'h0000;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
         first_q <= 1'b0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
         tmo_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         sz_q    <= sz_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         first_q <= first_d;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   // Memory fields are driven only while an access is in flight, so the
   // request drops the moment the state leaves ISSUE/WAIT (including reset).
   assign mem_req_rdwr      = active;
   assign mem_addr          = active ? addr_q : '0;
   assign mem_write_we      = active && we_q;
   assign mem_data_acc_sz   = active && sz_q;
   assign mem_write_data_8  = active ? wdata_q[7:0] : 8'h00;
   assign mem_write_data_16 = active ? wdata_q : 16'h0000;

   assign core_req_ready  = (state_q == IDLE);
   assign core_resp_valid = (state_q == RESP);
   assign core_resp_err   = (state_q == RESP) && err_q;
   assign core_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small byte-array memory model.
// 16-bit reads return {mem[a], mem[a+1]} (make_pair: first byte high).
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_valid, core_req_ready;
   logic [15:0] core_addr;
   logic        core_we, core_sz;
   logic [15:0] core_wdata;
   logic        core_resp_valid, core_resp_err;
   logic [15:0] core_rdata;
   logic        mem_req_rdwr;
   logic [15:0] mem_addr;
   logic [7:0]  mem_write_data_8;
   logic [15:0] mem_write_data_16;
   logic        mem_data_acc_sz, mem_write_we;
   logic [7:0]  mem_read_data_8;
   logic [15:0] mem_read_data_16;
   logic        mem_data_ready;

   int checks   = 0;
   int failures = 0;

   // memory model state
   logic [7:0] mem [0:65535];
   int         m_lat = 2;
   int         m_cnt = 0;
   logic       m_rdy = 1'b0;
   logic       stale = 1'b0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(16), .TIMEOUT_CYCLES(8'd32)) dut (
      .clk               (clk),
      .reset             (reset),
      .core_req_valid    (core_req_valid),
      .core_req_ready    (core_req_ready),
      .core_addr         (core_addr),
      .core_we           (core_we),
      .core_sz           (core_sz),
      .core_wdata        (core_wdata),
      .core_resp_valid   (core_resp_valid),
      .core_resp_err     (core_resp_err),
      .core_rdata        (core_rdata),
      .mem_req_rdwr      (mem_req_rdwr),
      .mem_addr          (mem_addr),
      .mem_write_data_8  (mem_write_data_8),
      .mem_write_data_16 (mem_write_data_16),
      .mem_data_acc_sz   (mem_data_acc_sz),
      .mem_write_we      (mem_write_we),
      .mem_read_data_8   (mem_read_data_8),
      .mem_read_data_16  (mem_read_data_16),
      .mem_data_ready    (mem_data_ready)
   );

   // Memory: registered ready rises m_lat cycles after the request appears
   // and stays up until the request drops; writes land when ready rises.
   always @(posedge clk) begin
      if (!reset) begin
         mem[16'h0004] <= 8'h12;
         mem[16'h0005] <= 8'h34;
         mem[16'h7FFD] <= 8'hFF;
         mem[16'hFFFF] <= 8'h5A;
      end
      if (!mem_req_rdwr) begin
         m_cnt <= 0;
         m_rdy <= 1'b0;
      end else if (!m_rdy) begin
         if (m_cnt >= m_lat - 1) begin
            m_rdy <= 1'b1;
            if (mem_write_we) begin
               if (mem_data_acc_sz) begin
                  mem[mem_addr]         <= mem_write_data_16[15:8];
                  mem[mem_addr + 16'd1] <= mem_write_data_16[7:0];
               end else begin
                  mem[mem_addr] <= mem_write_data_8;
               end
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   assign mem_data_ready   = m_rdy | stale;
   assign mem_read_data_8  = mem[mem_addr];
   assign mem_read_data_16 = {mem[mem_addr], mem[mem_addr + 16'd1]};

   // Drives one request and observes it to the response cycle.
   // lat counts negedges after the accepting edge (1 = cycle right after accept).
   task automatic run_access(input logic [15:0] a, input logic w, input logic s,
                             input logic [15:0] wd, input logic keep, input int stale_at,
                             output int lat, output int wait_n, output int rdwr_n,
                             output int we_n, output logic rdy_bad, output logic err,
                             output logic [15:0] rd);
      @(negedge clk);
      core_req_valid = 1'b1;
      core_addr = a; core_we = w; core_sz = s; core_wdata = wd;
      wait_n = 0;
      while (!core_req_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      @(negedge clk);
      if (!keep) core_req_valid = 1'b0;
      lat = 1; rdwr_n = 0; we_n = 0; rdy_bad = 1'b0;
      while (!core_resp_valid && lat < 200) begin
         if (mem_req_rdwr) rdwr_n++;
         if (mem_write_we) we_n++;
         if (core_req_ready) rdy_bad = 1'b1;
         stale = (lat == stale_at);
         @(negedge clk);
         lat++;
      end
      stale = 1'b0;
      err = core_resp_err;
      rd  = core_rdata;
      if (core_req_ready || mem_req_rdwr) rdy_bad = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      core_req_valid = 1'b0; core_addr = 16'h0; core_we = 1'b0; core_sz = 1'b0; core_wdata = 16'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({core_req_ready, core_resp_valid, core_resp_err, mem_req_rdwr, mem_write_we,
           mem_data_acc_sz, mem_addr, core_rdata} !== {1'b1, 5'b0, 16'h0, 16'h0}) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b rv=%b re=%b rdwr=%b we=%b sz=%b addr=%h rdata=%h, want ready=1 others 0",
                  core_req_ready, core_resp_valid, core_resp_err, mem_req_rdwr, mem_write_we,
                  mem_data_acc_sz, mem_addr, core_rdata);
      end
      reset = 1'b1;
   endtask

   task automatic test_read16();
      int lat, wn, rn, wen; logic bad, err; logic [15:0] rd;
      m_lat = 2;
      run_access(16'h0004, 1'b0, 1'b1, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if (lat !== 4) begin failures++; $display("FAIL rd16_latency: got %0d want 4", lat); end
      checks++; if (rn !== 3) begin failures++; $display("FAIL rd16_rdwr_cycles: got %0d want 3", rn); end
      checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL rd16_data: got %h want 1234", rd); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd16_err: got %b want 0", err); end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rd16_ready_low: got %b want 0", bad); end
      @(negedge clk);
      checks++; if (core_resp_valid !== 1'b0) begin failures++; $display("FAIL rd16_pulse: resp_valid=%b want 0", core_resp_valid); end
   endtask

   task automatic test_write_read8();
      int lat, wn, rn, wen; logic bad, err; logic [15:0] rd;
      m_lat = 2;
      run_access(16'h7FFC, 1'b1, 1'b0, 16'h33A5, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if (wen !== 3) begin failures++; $display("FAIL wr8_we_cycles: got %0d want 3", wen); end
      checks++; if (mem[16'h7FFC] !== 8'hA5) begin failures++; $display("FAIL wr8_mem: got %h want a5", mem[16'h7FFC]); end
      checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL wr8_rdata_held: got %h want 1234", rd); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr8_err: got %b want 0", err); end
      run_access(16'h7FFC, 1'b0, 1'b0, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if (rd !== 16'h00A5) begin failures++; $display("FAIL rd8_data: got %h want 00a5", rd); end
      checks++; if (wen !== 0) begin failures++; $display("FAIL rd8_we_cycles: got %0d want 0", wen); end
   endtask

   task automatic test_wrap_err();
      int lat, wn, rn, wen; logic bad, err; logic [15:0] rd;
      m_lat = 2;
      run_access(16'hFFFF, 1'b0, 1'b1, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if (lat !== 1) begin failures++; $display("FAIL wrap_latency: got %0d want 1", lat); end
      checks++; if (rn !== 0) begin failures++; $display("FAIL wrap_no_mem: rdwr cycles %0d want 0", rn); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL wrap_err: got %b want 1", err); end
      checks++; if (rd !== 16'h00A5) begin failures++; $display("FAIL wrap_rdata_held: got %h want 00a5", rd); end
      @(negedge clk);
      checks++; if ({core_resp_valid, core_req_ready} !== 2'b01) begin failures++; $display("FAIL wrap_after: rv,ready=%b want 01", {core_resp_valid, core_req_ready}); end
      run_access(16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if ({err, rd} !== {1'b0, 16'h005A}) begin failures++; $display("FAIL top_byte_read: err,data=%b,%h want 0,005a", err, rd); end
   endtask

   task automatic test_back_to_back();
      int lat, wn, rn, wen; logic bad, err; logic [15:0] rd;
      m_lat = 2;
      run_access(16'h0004, 1'b0, 1'b1, 16'h0, 1'b1, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if ({lat, bad, err, rd} !== {32'd4, 1'b0, 1'b0, 16'h1234}) begin failures++; $display("FAIL b2b_first: lat=%0d bad=%b err=%b rd=%h want 4 0 0 1234", lat, bad, err, rd); end
      m_lat = 4;
      run_access(16'h0100, 1'b1, 1'b1, 16'hBEEF, 1'b0, 2, lat, wn, rn, wen, bad, err, rd);
      checks++; if (wn !== 0) begin failures++; $display("FAIL b2b_accept_wait: got %0d want 0", wn); end
      checks++; if (lat !== 6) begin failures++; $display("FAIL b2b_stale_latency: got %0d want 6", lat); end
      checks++; if (rn !== 5) begin failures++; $display("FAIL b2b_rdwr_cycles: got %0d want 5", rn); end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL b2b_ready_low: got %b want 0", bad); end
      checks++; if ({mem[16'h0100], mem[16'h0101]} !== 16'hBEEF) begin failures++; $display("FAIL b2b_wr16_mem: got %h want beef", {mem[16'h0100], mem[16'h0101]}); end
   endtask

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      int lat, wn, rn, wen; logic bad, err; logic [15:0] rd;
      m_lat = 1000;
      run_access(16'h7FFC, 1'b0, 1'b1, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if (lat !== 34) begin failures++; $display("FAIL tmo_latency: got %0d want 34", lat); end
      checks++; if (rn !== 33) begin failures++; $display("FAIL tmo_rdwr_cycles: got %0d want 33", rn); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b want 1", err); end
      checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL tmo_rdata_held: got %h want 1234", rd); end
      m_lat = 32;
      run_access(16'h7FFC, 1'b0, 1'b0, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if ({lat, err, rd} !== {32'd34, 1'b0, 16'h00A5}) begin failures++; $display("FAIL tmo_ready_wins: lat=%0d err=%b rd=%h want 34 0 00a5", lat, err, rd); end
      m_lat = 2;
   endtask
`else
   task automatic test_no_timeout();
      int rn, rv, k;
      m_lat = 1000;
      @(negedge clk);
      core_req_valid = 1'b1; core_addr = 16'h7FFC; core_we = 1'b0; core_sz = 1'b1;
      @(negedge clk);
      core_req_valid = 1'b0;
      rn = 0; rv = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req_rdwr) rn++;
         if (core_resp_valid) rv++;
         @(negedge clk);
      end
      checks++; if ({rn, rv} !== {32'd40, 32'd0}) begin failures++; $display("FAIL hang_wait: rdwr=%0d resp=%0d want 40 0", rn, rv); end
      m_lat = 1;
      k = 0;
      while (!core_resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++; if ({core_resp_valid, core_resp_err, core_rdata} !== {1'b1, 1'b0, 16'hA5FF}) begin failures++; $display("FAIL hang_release: rv=%b err=%b rd=%h want 1 0 a5ff", core_resp_valid, core_resp_err, core_rdata); end
      m_lat = 2;
   endtask
`endif

   task automatic test_reset_mid();
      int lat, wn, rn, wen, rv; logic bad, err; logic [15:0] rd;
      m_lat = 1000;
      @(negedge clk);
      core_req_valid = 1'b1; core_addr = 16'h0004; core_we = 1'b0; core_sz = 1'b1;
      @(negedge clk);
      core_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (mem_req_rdwr !== 1'b1) begin failures++; $display("FAIL rstmid_in_wait: rdwr=%b want 1", mem_req_rdwr); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({mem_req_rdwr, core_req_ready, core_resp_valid} !== 3'b010) begin failures++; $display("FAIL rstmid_async: rdwr,ready,rv=%b want 010", {mem_req_rdwr, core_req_ready, core_resp_valid}); end
      checks++; if (core_rdata !== 16'h0000) begin failures++; $display("FAIL rstmid_rdata_clr: got %h want 0000", core_rdata); end
      m_lat = 2;
      @(negedge clk);
      reset = 1'b1;
      rv = 0;
      repeat (5) begin
         @(negedge clk);
         if (core_resp_valid) rv++;
      end
      checks++; if (rv !== 0) begin failures++; $display("FAIL rstmid_no_resp: got %0d want 0", rv); end
      run_access(16'h0004, 1'b0, 1'b1, 16'h0, 1'b0, -1, lat, wn, rn, wen, bad, err, rd);
      checks++; if ({lat, err, rd} !== {32'd4, 1'b0, 16'h1234}) begin failures++; $display("FAIL rstmid_recover: lat=%0d err=%b rd=%h want 4 0 1234", lat, err, rd); end
   endtask

   initial begin
      test_reset();
      test_read16();
      test_write_read8();
      test_wrap_err();
      test_back_to_back();
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures + 1);
      $fatal(1);
   end

endmodule
